program_sequencer: RTL and testbench

Instruction source for the simple processor. It stores a program written by a host, then drives the processor's Din and run inputs and advances on the processor's Done pulse. For mvi it presents the immediate word on the cycle after issue. It replaces the free-running ROM/up-counter feed with a Done-paced handshake.

---
 rtl/program_sequencer.sv | 142 ++++++++++++++
 tb/tb_program_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - host-loaded program buffer feeding Din/run, paced by Done
// Optional Done watchdog enabled by defining PROGSEQ_TIMEOUT_EN.
module program_sequencer #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [8:0]    wr_data,
  input  logic          clr,
  input  logic          start,
  input  logic          Done,
  output logic          run,
  output logic [8:0]    Din,
  output logic [AW-1:0] pc,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          full,
  output logic          prog_done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t        state, state_nxt;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [8:0]    cur_word;
  logic          cur_mvi;
  logic [AW:0]   pc_ext, pc_plus1, pc_step;
  logic          mem_we, go;

  assign cur_word = mem[pc];
  assign cur_mvi  = (cur_word[8:6] == 3'b001);
  assign pc_ext   = {1'b0, pc};
  assign pc_plus1 = pc_ext + (AW+1)'(1);
  assign pc_step  = cur_mvi ? pc_ext + (AW+1)'(2) : pc_plus1;

  assign full      = (count == (AW+1)'(DEPTH));
  assign busy      = (state == S_ISSUE) || (state == S_WAIT);
  assign prog_done = (state == S_FIN);
  assign go        = start && !clr && (count != '0);
  assign mem_we    = (state == S_IDLE) && wr_en && !clr && !full;

`ifdef PROGSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          timed_out;

  assign timed_out = (state == S_WAIT) && !Done && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (Done) state_nxt = (pc_step >= count) ? S_FIN : S_ISSUE;
`ifdef PROGSEQ_TIMEOUT_EN
        else if (timed_out) state_nxt = S_FIN;
`endif
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Buffer contents survive reset, so the write port has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      Din    <= '0;
      pc     <= '0;
      count  <= '0;
      wr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      run <= (state == S_ISSUE);
      case (state)
        S_IDLE: begin
          if (clr) begin
            count  <= '0;
            wr_ptr <= '0;
            err    <= 1'b0;
          end else if (wr_en) begin
            if (full) begin
              err <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
              count  <= count + (AW+1)'(1);
            end
          end
          if (go) pc <= '0;
        end
        S_ISSUE: Din <= cur_word;
        S_WAIT: begin
          // run is high only on the first WAIT cycle: that is the immediate slot.
          if (run && cur_mvi) begin
            if (pc_plus1 == count) begin
              Din <= '0;
              err <= 1'b1;
            end else begin
              Din <= mem[pc_plus1[AW-1:0]];
            end
          end
          if (Done && (pc_step < count)) pc <= pc_step[AW-1:0];
`ifdef PROGSEQ_TIMEOUT_EN
          if (timed_out) err <= 1'b1;
`endif
        end
        S_FIN: begin
          Din <= '0;
          pc  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - randomized self-checking bench for program_sequencer
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst, wr_en, clr, start, Done;
  logic [8:0] wr_data;
  logic       run, busy, full, prog_done, err;
  logic [8:0] Din;
  logic [4:0] pc;
  logic [5:0] count;

  program_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .start(start), .Done(Done), .run(run), .Din(Din), .pc(pc),
    .count(count), .busy(busy), .full(full), .prog_done(prog_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the loaded program as a plain array plus a sticky error bit.
  logic [8:0] m_mem [32];
  int         m_count;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_buf();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  task automatic write_word(input logic [8:0] w);
    wr_en = 1'b1; wr_data = w;
    @(negedge clk);
    wr_en = 1'b0;
    if (m_count < 32) begin
      m_mem[m_count] = w;
      m_count++;
    end else begin
      m_err = 1'b1;
    end
  endtask

  function automatic logic [8:0] rand_word();
    logic [2:0] op;
    op = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
    return {op, 6'($urandom)};
  endfunction

  // Walks the reference program; fixed_dly < 0 picks a random Done delay per instruction.
  task automatic run_prog(input int fixed_dly);
    int p, n, dly;
    logic is_mvi;
    logic [8:0] imm;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    p = 0;
    while (p < m_count) begin
      n = 0;
      while (run !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("run_issue", run, 1);
      chk("din_word", Din, m_mem[p]);
      chk("pc", pc, p);
      chk("busy", busy, 1);
      is_mvi = (m_mem[p][8:6] == 3'b001);
      dly = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 4);
      if (is_mvi) begin
        @(negedge clk);
        if (p + 1 < m_count) imm = m_mem[p+1];
        else begin imm = '0; m_err = 1'b1; end
        chk("din_imm", Din, imm);
        chk("run_pulse", run, 0);
        dly = (dly > 0) ? dly - 1 : 0;
      end
      for (int i = 0; i < dly; i++) begin
        wr_en = 1'($urandom); wr_data = 9'($urandom);
        clr = 1'($urandom); start = 1'($urandom);
        @(negedge clk);
      end
      wr_en = 1'b0; clr = 1'b0; start = 1'b0; Done = 1'b1;
      @(negedge clk);
      Done = 1'b0;
      p += is_mvi ? 2 : 1;
    end
    chk("prog_done", prog_done, 1);
    chk("busy_fin", busy, 0);
    @(negedge clk);
    chk("prog_done_pulse", prog_done, 0);
    chk("pc_home", pc, 0);
    chk("din_home", Din, 0);
    chk("count", count, m_count);
    chk("err", err, m_err);
  endtask

  task automatic expect_no_run(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen |= run | busy;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int n;
    logic hold;
    rst = 1'b1; wr_en = 1'b0; clr = 1'b0; start = 1'b0; Done = 1'b0; wr_data = '0;
    m_count = 0; m_err = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_run", run, 0);
    chk("rst_din", Din, 0);
    chk("rst_pc", pc, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_pdone", prog_done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // mvi R0 / #5 / add R0,R0 with Done four cycles after each run
    clr_buf();
    write_word(9'h040); write_word(9'h005); write_word(9'h080);
    run_prog(4);

    // overfill: 33rd word is dropped and flags err
    clr_buf();
    for (int i = 0; i < 33; i++) write_word(rand_word());
    chk("ovf_count", count, 32);
    chk("ovf_full", full, 1);
    chk("ovf_err", err, 1);
    run_prog(-1);
    clr_buf();
    chk("clr_count", count, 0);
    chk("clr_err", err, 0);
    chk("clr_full", full, 0);

    // start on an empty buffer does nothing
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    expect_no_run("empty_start", 8);

    // lone mvi: immediate slot reads zero and err is raised
    clr_buf();
    write_word(9'h040);
    run_prog(-1);

    // random programs, each run twice to confirm the buffer is retained
    for (int k = 0; k < 6; k++) begin
      clr_buf();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) write_word(rand_word());
      run_prog(-1);
      run_prog(-1);
    end

    // asynchronous reset while waiting for Done
    clr_buf();
    write_word(9'h080); write_word(9'h0C0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (run !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("arst_in_wait", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_run", run, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    chk("arst_din", Din, 0);
    @(negedge clk); rst = 1'b0;
    m_count = 0; m_err = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    expect_no_run("arst_no_restart", 8);

    // Done never arrives
    write_word(9'h080); write_word(9'h0C0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
`ifdef PROGSEQ_TIMEOUT_EN
    n = 0;
    while (prog_done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("to_done", prog_done, 1);
    chk("to_latency", n, 16);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    @(negedge clk);
    chk("to_pc", pc, 0);
`else
    hold = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      hold &= busy;
    end
    chk("wait_hold", hold, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
